// File: rtl/axi_sram_burst_slave.sv
// axi_sram_burst_slave
//   AXI slave in front of a single-port synchronous SRAM. It accepts FIXED, INCR
//   and WRAP bursts on both channels, one transaction at a time. Simultaneous
//   read and write requests are granted round-robin. Illegal bursts, beats that
//   fall outside the memory, and WLAST misplacement are reported as SLVERR.
//
// Ports
//   ACLK, ARESET                       clock, synchronous active-high reset
//   AW* / AWVALID / AWREADY            write address channel
//   WDATA / WSTRB / WLAST / WVALID / WREADY   write data channel
//   BID / BRESP / BVALID / BREADY      write response channel
//   AR* / ARVALID / ARREADY            read address channel
//   RID / RDATA / RRESP / RLAST / RVALID / RREADY   read data channel
module axi_sram_burst_slave #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int ID_W      = 8,
  parameter int LEN_W     = 4,
  parameter int MEM_WORDS = 16384
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ID_W-1:0]       AWID,
  input  logic [ADDR_W-1:0]     AWADDR,
  input  logic [LEN_W-1:0]      AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic [1:0]            AWBURST,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_W-1:0]     WDATA,
  input  logic [DATA_W/8-1:0]   WSTRB,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [ID_W-1:0]       BID,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ID_W-1:0]       ARID,
  input  logic [ADDR_W-1:0]     ARADDR,
  input  logic [LEN_W-1:0]      ARLEN,
  input  logic [2:0]            ARSIZE,
  input  logic [1:0]            ARBURST,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [ID_W-1:0]       RID,
  output logic [DATA_W-1:0]     RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY
);

  localparam int NB      = DATA_W / 8;
  localparam int NB_LOG2 = $clog2(NB);
  localparam int MEM_AW  = $clog2(MEM_WORDS);
  localparam logic [2:0] MAX_SIZE    = 3'(NB_LOG2);
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, W_ADDR, W_DATA, W_RESP, R_ADDR, R_DATA} state_t;

  state_t              state;
  logic                rr;        // 1: read was granted last, so write wins the next tie
  logic [ID_W-1:0]     id_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    cnt_q;
  logic [2:0]          size_q;
  logic [1:0]          burst_q;
  logic                berr_q;    // burst itself is illegal: no writes, every read beat errors
  logic                err_q;     // accumulated write-response error

  logic [DATA_W-1:0]   mem [MEM_WORDS];
  logic [DATA_W-1:0]   mem_q;
  logic [ADDR_W-1:0]   rd_addr;
  logic [MEM_AW-1:0]   rd_idx;
  logic [ADDR_W-1:0]   nxt_addr;
  logic                cur_oor;
  logic                last_beat;
  logic                w_bad;
  logic                mem_we;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [2:0]        size,
                                                  input logic [LEN_W-1:0]  len,
                                                  input logic [1:0]        burst);
    logic [ADDR_W-1:0] bytes;
    logic [ADDR_W-1:0] wsize;
    bytes = ADDR_W'(1) << size;
    wsize = (ADDR_W'(len) + ADDR_W'(1)) << size;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~(wsize - 1'b1)) + ((addr + bytes) & (wsize - 1'b1));
      default:     next_addr = (addr & ~(bytes - 1'b1)) + bytes;  // INCR and reserved
    endcase
  endfunction

  function automatic logic burst_err(input logic [2:0]       size,
                                     input logic [LEN_W-1:0] len,
                                     input logic [1:0]       burst);
    int unsigned beats;
    beats = 32'(len) + 32'd1;
    burst_err = (size > MAX_SIZE) || (burst == BURST_RSVD) ||
                ((burst == BURST_WRAP) && !(beats inside {2, 4, 8, 16}));
  endfunction

  function automatic logic out_of_range(input logic [ADDR_W-1:0] addr);
    out_of_range = (addr >> NB_LOG2) >= ADDR_W'(MEM_WORDS);
  endfunction

  assign nxt_addr  = next_addr(addr_q, size_q, len_q, burst_q);
  assign cur_oor   = out_of_range(addr_q);
  assign last_beat = (cnt_q == len_q);
  // Any of these makes the write response SLVERR; the length still comes from AWLEN.
  assign w_bad     = (WLAST != last_beat) || cur_oor;
  assign mem_we    = (state == W_DATA) && WVALID && WREADY && !berr_q && !cur_oor;

  // Pre-fetch the next beat on an R handshake so data streams without bubbles;
  // otherwise re-read the current beat so RDATA holds while RREADY is low.
  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    rd_addr = addr_q;
    if (state == R_ADDR)
      rd_addr = ARADDR;
    else if (state == R_DATA && RREADY)
      rd_addr = nxt_addr;
  end

  assign rd_idx = out_of_range(rd_addr) ? '0 : rd_addr[NB_LOG2 +: MEM_AW];

  // NOTE: the memory array has no reset; its contents survive ARESET.
  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++)
        if (WSTRB[b]) mem[addr_q[NB_LOG2 +: MEM_AW]][8*b +: 8] <= WDATA[8*b +: 8];
    end
    mem_q <= mem[rd_idx];
  end

  // Errored read beats return zero data.
  assign RDATA = (RVALID && RRESP == RESP_OKAY) ? mem_q : '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state   <= IDLE;
      rr      <= 1'b1;
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BID     <= '0;
      BRESP   <= RESP_OKAY;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RID     <= '0;
      RRESP   <= RESP_OKAY;
      RLAST   <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      berr_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (AWVALID && (!ARVALID || rr)) begin
            state   <= W_ADDR;
            AWREADY <= 1'b1;
            rr      <= 1'b0;
          end else if (ARVALID) begin
            state   <= R_ADDR;
            ARREADY <= 1'b1;
            rr      <= 1'b1;
          end
        end
        W_ADDR: begin
          if (AWVALID && AWREADY) begin
            id_q    <= AWID;
            addr_q  <= AWADDR;
            len_q   <= AWLEN;
            size_q  <= AWSIZE;
            burst_q <= AWBURST;
            cnt_q   <= '0;
            berr_q  <= burst_err(AWSIZE, AWLEN, AWBURST);
            err_q   <= burst_err(AWSIZE, AWLEN, AWBURST);
            AWREADY <= 1'b0;
            WREADY  <= 1'b1;
            state   <= W_DATA;
          end
        end
        W_DATA: begin
          if (WVALID && WREADY) begin
            addr_q <= nxt_addr;
            cnt_q  <= cnt_q + 1'b1;
            if (last_beat) begin
              WREADY <= 1'b0;
              BVALID <= 1'b1;
              BID    <= id_q;
              BRESP  <= (err_q || w_bad) ? RESP_SLVERR : RESP_OKAY;
              state  <= W_RESP;
            end else if (w_bad) begin
              err_q <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (BREADY) begin
            BVALID <= 1'b0;
            state  <= IDLE;
          end
        end
        R_ADDR: begin
          if (ARVALID && ARREADY) begin
            id_q    <= ARID;
            addr_q  <= ARADDR;
            len_q   <= ARLEN;
            size_q  <= ARSIZE;
            burst_q <= ARBURST;
            cnt_q   <= '0;
            berr_q  <= burst_err(ARSIZE, ARLEN, ARBURST);
            ARREADY <= 1'b0;
            RVALID  <= 1'b1;
            RID     <= ARID;
            RRESP   <= (burst_err(ARSIZE, ARLEN, ARBURST) || out_of_range(ARADDR))
                       ? RESP_SLVERR : RESP_OKAY;
            RLAST   <= (ARLEN == '0);
            state   <= R_DATA;
          end
        end
        R_DATA: begin
          if (RREADY) begin
            if (RLAST) begin
              RVALID <= 1'b0;
              RLAST  <= 1'b0;
              RRESP  <= RESP_OKAY;
              state  <= IDLE;
            end else begin
              addr_q <= nxt_addr;
              cnt_q  <= cnt_q + 1'b1;
              RRESP  <= (berr_q || out_of_range(nxt_addr)) ? RESP_SLVERR : RESP_OKAY;
              RLAST  <= ((cnt_q + 1'b1) == len_q);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_burst_slave.sv
// tb_axi_sram_burst_slave
//   Directed bench for axi_sram_burst_slave with the default parameters
//   (32-bit data, 16K words). Write and read tasks drive the channels and
//   compare every response beat against hand-computed values.
module tb_axi_sram_burst_slave;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int ID_W      = 8;
  localparam int LEN_W     = 4;
  localparam int MEM_WORDS = 16384;
  localparam int NB        = DATA_W / 8;

  logic              ACLK;
  logic              ARESET;
  logic [ID_W-1:0]   AWID;
  logic [ADDR_W-1:0] AWADDR;
  logic [LEN_W-1:0]  AWLEN;
  logic [2:0]        AWSIZE;
  logic [1:0]        AWBURST;
  logic              AWVALID;
  logic              AWREADY;
  logic [DATA_W-1:0] WDATA;
  logic [NB-1:0]     WSTRB;
  logic              WLAST;
  logic              WVALID;
  logic              WREADY;
  logic [ID_W-1:0]   BID;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic [ID_W-1:0]   ARID;
  logic [ADDR_W-1:0] ARADDR;
  logic [LEN_W-1:0]  ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic              ARVALID;
  logic              ARREADY;
  logic [ID_W-1:0]   RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;

  int          n_pass   = 0;
  int          n_checks = 0;
  logic [31:0] wr_d [16];
  logic [31:0] exp_d [16];
  logic [7:0]  id_ctr = 8'h10;

  axi_sram_burst_slave #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .LEN_W(LEN_W), .MEM_WORDS(MEM_WORDS)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Write burst from IDLE: AWREADY must follow one cycle after AWVALID, W beats
  // are offered back to back and must be accepted immediately, BVALID must
  // follow the final beat at once. last_at is the beat index carrying WLAST.
  task automatic axi_write(input string tag, input logic [31:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [3:0] strb, input int last_at, input logic [1:0] resp);
    int n;
    logic [7:0] id;
    id = id_ctr;
    id_ctr++;
    AWID = id; AWADDR = addr; AWLEN = 4'(len); AWSIZE = size; AWBURST = burst;
    AWVALID = 1'b1;
    n = 0;
    while (!AWREADY && n < 50) begin
      @(posedge ACLK); #1;
      n++;
    end
    check({tag, "_aw_latency"}, 64'(n), 64'd1);
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    for (int b = 0; b <= len; b++) begin
      WVALID = 1'b1; WDATA = wr_d[b]; WSTRB = strb; WLAST = (b == last_at);
      check($sformatf("%s_wready%0d", tag, b), WREADY, 1'b1);
      @(posedge ACLK); #1;
    end
    WVALID = 1'b0; WLAST = 1'b0;
    BREADY = 1'b1;
    check({tag, "_bvalid"}, BVALID, 1'b1);
    check({tag, "_bresp"}, BRESP, resp);
    check({tag, "_bid"}, BID, id);
    @(posedge ACLK); #1;
    BREADY = 1'b0;
    check({tag, "_bvalid_clear"}, BVALID, 1'b0);
  endtask

  // Read burst with RREADY held high: the first beat must appear the cycle after
  // the AR handshake and the rest on consecutive cycles. exp_d holds the data.
  task automatic axi_read(input string tag, input logic [31:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [1:0] resp);
    int n;
    logic [7:0] id;
    id = id_ctr;
    id_ctr++;
    ARID = id; ARADDR = addr; ARLEN = 4'(len); ARSIZE = size; ARBURST = burst;
    ARVALID = 1'b1;
    RREADY = 1'b1;
    n = 0;
    while (!ARREADY && n < 50) begin
      @(posedge ACLK); #1;
      n++;
    end
    check({tag, "_arready"}, ARREADY, 1'b1);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    for (int b = 0; b <= len; b++) begin
      check($sformatf("%s_rvalid%0d", tag, b), RVALID, 1'b1);
      check($sformatf("%s_rdata%0d", tag, b), RDATA, exp_d[b]);
      check($sformatf("%s_rresp%0d", tag, b), RRESP, resp);
      check($sformatf("%s_rlast%0d", tag, b), RLAST, (b == len));
      check($sformatf("%s_rid%0d", tag, b), RID, id);
      @(posedge ACLK); #1;
    end
    RREADY = 1'b0;
    check({tag, "_rvalid_clear"}, RVALID, 1'b0);
  endtask

  initial begin
    ARESET = 1'b1;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
    RREADY = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;

    // Reset state: every output low.
    check("rst_awready", AWREADY, 1'b0);
    check("rst_wready", WREADY, 1'b0);
    check("rst_bvalid", BVALID, 1'b0);
    check("rst_bid_bresp", {BID, BRESP}, '0);
    check("rst_arready", ARREADY, 1'b0);
    check("rst_rvalid", RVALID, 1'b0);
    check("rst_rid_rresp_rlast", {RID, RRESP, RLAST}, '0);
    check("rst_rdata", RDATA, '0);
    ARESET = 1'b0;

    // Simultaneous AW/AR straight out of reset: write wins, then the read
    // returns the freshly written word.
    ARADDR = 32'h200; ARLEN = '0; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b1;
    wr_d[0] = 32'hCAFE_F00D;
    axi_write("arb1_wr", 32'h200, 0, 3'd2, 2'b01, 4'hF, 0, 2'b00);
    exp_d[0] = 32'hCAFE_F00D;
    axi_read("arb1_rd", 32'h200, 0, 3'd2, 2'b01, 2'b00);

    // Read was granted last, so the next tie goes to the write again.
    ARADDR = 32'h204; ARLEN = '0; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b1;
    wr_d[0] = 32'h0BAD_BEEF;
    axi_write("arb2_wr", 32'h204, 0, 3'd2, 2'b01, 4'hF, 0, 2'b00);
    exp_d[0] = 32'h0BAD_BEEF;
    axi_read("arb2_rd", 32'h204, 0, 3'd2, 2'b01, 2'b00);

    // INCR burst of four words at 0x100, read back in four consecutive cycles.
    for (int i = 0; i < 4; i++) wr_d[i] = 32'hA0 + 32'(i);
    axi_write("incr_wr", 32'h100, 3, 3'd2, 2'b01, 4'hF, 3, 2'b00);
    for (int i = 0; i < 4; i++) exp_d[i] = 32'hA0 + 32'(i);
    axi_read("incr_rd", 32'h100, 3, 3'd2, 2'b01, 2'b00);

    // Byte strobes: only lanes 0 and 2 are overwritten.
    wr_d[0] = 32'hFFFF_FFFF;
    axi_write("strb_fill", 32'h20, 0, 3'd2, 2'b01, 4'hF, 0, 2'b00);
    wr_d[0] = 32'h1234_5678;
    axi_write("strb_wr", 32'h20, 0, 3'd2, 2'b01, 4'b0101, 0, 2'b00);
    exp_d[0] = 32'hFF34_FF78;
    axi_read("strb_rd", 32'h20, 0, 3'd2, 2'b01, 2'b00);

    // WRAP from 0x38 over a 16-byte window: 0x38, 0x3C, 0x30, 0x34. FIXED stays at 0x38.
    for (int i = 0; i < 4; i++) wr_d[i] = 32'hB0 + 32'(i);
    axi_write("wrap_fill", 32'h30, 3, 3'd2, 2'b01, 4'hF, 3, 2'b00);
    exp_d[0] = 32'hB2; exp_d[1] = 32'hB3; exp_d[2] = 32'hB0; exp_d[3] = 32'hB1;
    axi_read("wrap_rd", 32'h38, 3, 3'd2, 2'b10, 2'b00);
    for (int i = 0; i < 3; i++) exp_d[i] = 32'hB2;
    axi_read("fixed_rd", 32'h38, 2, 3'd2, 2'b00, 2'b00);

    // Out-of-range burst at word MEM_WORDS: SLVERR, low memory left untouched.
    wr_d[0] = 32'h55AA_55AA; wr_d[1] = 32'h1111_2222;
    axi_write("oor_fill", 32'h0, 1, 3'd2, 2'b01, 4'hF, 1, 2'b00);
    wr_d[0] = 32'hDEAD_0000; wr_d[1] = 32'hDEAD_0001;
    axi_write("oor_wr", 32'(MEM_WORDS * NB), 1, 3'd2, 2'b01, 4'hF, 1, 2'b10);
    exp_d[0] = 32'h0; exp_d[1] = 32'h0;
    axi_read("oor_rd", 32'(MEM_WORDS * NB), 1, 3'd2, 2'b01, 2'b10);
    exp_d[0] = 32'h55AA_55AA; exp_d[1] = 32'h1111_2222;
    axi_read("oor_mem", 32'h0, 1, 3'd2, 2'b01, 2'b00);

    // WLAST on beat 0 of a 4-beat write: all four beats still accepted, SLVERR.
    for (int i = 0; i < 4; i++) wr_d[i] = 32'hC0 + 32'(i);
    axi_write("wlast_early", 32'h300, 3, 3'd2, 2'b01, 4'hF, 0, 2'b10);

    // Illegal size and illegal WRAP length: zero data, SLVERR on every beat.
    exp_d[0] = 32'h0; exp_d[1] = 32'h0; exp_d[2] = 32'h0;
    axi_read("bad_size", 32'h100, 0, 3'd3, 2'b01, 2'b10);
    axi_read("bad_wrap", 32'h100, 2, 3'd2, 2'b10, 2'b10);

    // Reset during beat 1 of a 4-beat read abandons the burst.
    ARID = 8'h77; ARADDR = 32'h100; ARLEN = 4'd3; ARSIZE = 3'd2; ARBURST = 2'b01;
    ARVALID = 1'b1; RREADY = 1'b1;
    for (int n = 0; n < 50 && !ARREADY; n++) begin
      @(posedge ACLK); #1;
    end
    check("mid_arready", ARREADY, 1'b1);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    check("mid_beat0", RDATA, 32'hA0);
    @(posedge ACLK); #1;
    check("mid_beat1", RDATA, 32'hA1);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0; RREADY = 1'b0;
    check("mid_rvalid", RVALID, 1'b0);
    check("mid_rlast_rdata", {RLAST, RDATA}, '0);
    check("mid_readies", {ARREADY, AWREADY, WREADY, BVALID}, '0);
    for (int i = 0; i < 4; i++) exp_d[i] = 32'hA0 + 32'(i);
    axi_read("post_rst_rd", 32'h100, 3, 3'd2, 2'b01, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_sram_burst_slave.md
# axi_sram_burst_slave

Parametrised AXI slave with an internal single-port synchronous memory. It is the next-generation SRAM endpoint on the AXI interconnect, replacing the fixed 32-bit/16K-word wrapper. Over the earlier wrapper it adds:
- FIXED, INCR and WRAP bursts on both channels, with per-beat address advance on writes;
- round-robin arbitration between simultaneous read and write requests;
- SLVERR reporting for out-of-range, illegal-size, illegal-wrap and WLAST-mismatch conditions.

## Interface
Parameters:
- DATA_W, 32: data bus width in bits; power of 2, 32..128. NB = DATA_W/8 bytes per word.
- ADDR_W, 32: AXI address width.
- ID_W, 8: AXI ID width.
- LEN_W, 4: AxLEN width. Bursts are 1..2^LEN_W beats.
- MEM_WORDS, 16384: memory depth in DATA_W words.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  synchronous, active-high reset.
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID_W/ADDR_W/LEN_W/3/2  write address; AWVALID in 1, AWREADY out 1.
- WDATA/WSTRB/WLAST  in  DATA_W/NB/1  write data; WVALID in 1, WREADY out 1.
- BID/BRESP  out  ID_W/2  write response; BVALID out 1, BREADY in 1.
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID_W/ADDR_W/LEN_W/3/2  read address; ARVALID in 1, ARREADY out 1.
- RID/RDATA/RRESP/RLAST  out  ID_W/DATA_W/2/1  read data; RVALID out 1, RREADY in 1.

## Operation
- States: IDLE, W_ADDR, W_DATA, W_RESP, R_ADDR, R_DATA. One transaction is in flight at a time.
- IDLE arbitration:
  - AWVALID only: go to W_ADDR. ARVALID only: go to R_ADDR.
  - Both asserted: grant the channel not granted last. A 1-bit rr flag records the last grant and is updated on each grant.
- W_ADDR: AWREADY=1. On handshake, latch ID, addr, len, size, burst, set beat counter to 0, go to W_DATA.
- W_DATA: WREADY=1. On each W handshake:
  - If the beat is in range and no burst error is flagged, write the memory at the beat word address, enabling byte lanes per WSTRB.
  - Advance the beat address and increment the beat counter.
  - The beat with counter==len ends the burst; go to W_RESP.
  - WLAST on any other beat, or absent on the final beat, sets the error flag. The burst length is still taken from AWLEN.
- W_RESP: BVALID=1, BID=latched ID. BRESP=SLVERR (2'b10) if the error flag is set, else OKAY. Go to IDLE on BREADY.
- R_ADDR: ARREADY=1. On handshake, latch fields and go to R_DATA.
- R_DATA: RVALID=1, RID=latched ID, RLAST=(counter==len).
  - RDATA is memory read data, or 0 for an errored beat. RRESP is per beat: SLVERR if the beat is out of range or the burst is illegal.
  - On an R handshake: advance address and counter; if RLAST, go to IDLE.
- Burst errors, flagged for the whole burst:
  - AxSIZE > log2(NB).
  - AxBURST=2'b11.
  - WRAP with len+1 not in {2,4,8,16}.
  - Reserved burst type (2'b11) advances as INCR.
- Address arithmetic, with bytes = 1<<size:
  - FIXED: address unchanged.
  - INCR: next = (addr & ~(bytes-1)) + bytes, computed at ADDR_W width; wraps modulo 2^ADDR_W.
  - WRAP: wsize = (len+1)*bytes, base = addr & ~(wsize-1), next = base + ((addr+bytes) & (wsize-1)).
- Word address = addr >> log2(NB). A beat is out of range if word address >= MEM_WORDS.
  - Out-of-range write: memory is not written.
  - Out-of-range read: RDATA=0 for that beat.
- Memory: single port, synchronous read with 1-cycle latency. Write takes priority, but the two never overlap in time.
  - The read address in R_DATA is the next-beat address on an R handshake, otherwise the current beat address.
  - This gives one beat per cycle with no bubbles under continuous RREADY.

## Timing
- Reset (ARESET=1 at a clock edge): state=IDLE, rr=read-granted-last so that write wins the first tie. All outputs are 0: the ready and valid signals, BID, BRESP, RID, RDATA, RRESP, RLAST.
  - Memory contents are not reset.
  - Reset mid-burst abandons the transaction: no B response and no further R beats.
- AWVALID seen in IDLE at cycle T: AWREADY=1 at T+1. WREADY is first 1 at T+2.
- Final W beat accepted at cycle U: BVALID=1 from U+1 until the BREADY handshake. IDLE the cycle after.
- AR handshake at cycle V: the first RVALID with valid RDATA is at V+1.
- With RREADY held high, beats arrive on consecutive cycles.
- RVALID, RDATA, RRESP and RLAST hold stable while RREADY=0.
- Back-to-back transactions: minimum 1 IDLE cycle between a response completing and the next address phase.

## Test plan
- Write INCR, AWADDR=0x100, AWLEN=3, size 2, WSTRB=4'hF, data 0xA0..0xA3, then read the same burst -> RDATA A0,A1,A2,A3 in 4 consecutive cycles; RLAST on beat 4; BRESP=RRESP=OKAY.
- Write 0xFFFFFFFF to 0x20, then a single beat 0x12345678 with WSTRB=4'b0101; read 0x20 -> 0xFF34FF78.
- WRAP read, ARADDR=0x38, ARLEN=3, size 2 -> addresses 0x38, 0x3C, 0x30, 0x34. FIXED read, len 2 -> 0x38 three times.
- AWVALID and ARVALID both raised from reset -> write granted first; after BREADY the read is granted. The next simultaneous request grants the write.
- Write to word MEM_WORDS with len 1 -> BRESP=SLVERR and memory unchanged. Read at the same address -> RDATA=0, RRESP=SLVERR on both beats. WLAST on beat 1 of a 4-beat write -> 4 beats accepted, BRESP=SLVERR.
- ARESET asserted during beat 2 of a 4-beat read -> next cycle RVALID=0, state IDLE. A new read after reset completes normally.
